// File: rtl/sys_pkg.sv
// Shared types and constants for the machine-mode system unit:
// op encoding, CSR sub-op codes, CSR addresses and mstatus field positions.
package sys_pkg;

  typedef enum logic [1:0] {
    OP_CSR    = 2'd0,
    OP_ECALL  = 2'd1,
    OP_EBREAK = 2'd2,
    OP_MRET   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAP,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  // 000 and 100 are the only func3 encodings with no CSR meaning
  function automatic logic legal_func3(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sys_csr_trap_unit_csr_alu.sv
// Combinational CSR read-modify-write: operand select, rw/rs/rc and the
// "no write when rs1/zimm is zero" rule for set/clear forms.
module sys_csr_trap_unit_csr_alu
  import sys_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src1,
  input  logic [4:0]      src1_id,
  output logic [XLEN-1:0] new_val,
  output logic            wr_en
);

  logic [XLEN-1:0] operand;

  always_comb begin
    operand = func3[2] ? XLEN'(src1_id) : src1;
    new_val = operand;
    unique case (func3[1:0])
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = operand;
    endcase
    wr_en = (func3[1:0] == 2'b01) || (src1_id != 5'd0);
  end

endmodule

// File: rtl/sys_csr_trap_unit.sv
// Machine-mode CSR file with csr ops, ecall/ebreak trap entry and mret,
// behind a valid/ready request and a registered single-cycle response.
module sys_csr_trap_unit
  import sys_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST   = 64'h0000_000a_0000_1800,
  parameter int              MCAUSE_ECALL  = 11,
  parameter int              MCAUSE_EBREAK = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [2:0]      func3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] src1,
  input  logic [4:0]      src1_id,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      dst_id,
  output logic            resp_valid,
  output logic            wb_vld,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal
);

  localparam logic [XLEN-1:0] LOW2_MASK = ~XLEN'(3);

  state_e          state_reg, state_next;
  logic [XLEN-1:0] mstatus_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
  logic            trap_ebreak_reg;
  logic            accept;
  logic            addr_ok;
  logic [XLEN-1:0] csr_old;
  logic [XLEN-1:0] alu_new;
  logic            alu_wr;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    csr_old = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  csr_old = mstatus_reg;
      CSR_MTVEC:    csr_old = mtvec_reg;
      CSR_MSCRATCH: csr_old = mscratch_reg;
      CSR_MEPC:     csr_old = mepc_reg;
      CSR_MCAUSE:   csr_old = mcause_reg;
      default:      addr_ok = 1'b0;
    endcase
  end

  sys_csr_trap_unit_csr_alu #(.XLEN(XLEN)) u_csr_alu (
    .func3   (func3),
    .old_val (csr_old),
    .src1    (src1),
    .src1_id (src1_id),
    .new_val (alu_new),
    .wr_en   (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (op_e'(op) == OP_ECALL || op_e'(op) == OP_EBREAK) state_next = ST_TRAP;
          else                                                 state_next = ST_RESP;
        end
      end
      ST_TRAP: state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_reg     <= MSTATUS_RST;
      mtvec_reg       <= '0;
      mscratch_reg    <= '0;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
      trap_ebreak_reg <= 1'b0;
      resp_valid      <= 1'b0;
      wb_vld          <= 1'b0;
      wb_addr         <= '0;
      wb_data         <= '0;
      redirect_vld    <= 1'b0;
      redirect_pc     <= '0;
      illegal         <= 1'b0;
    end else begin
      // Response fields are pulses: cleared unless this edge enters RESP
      resp_valid   <= 1'b0;
      wb_vld       <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
      illegal      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            case (op_e'(op))
              OP_CSR: begin
                resp_valid <= 1'b1;
                if (!addr_ok || !legal_func3(func3)) begin
                  illegal <= 1'b1;
                end else begin
                  wb_vld  <= (dst_id != 5'd0);
                  wb_addr <= dst_id;
                  wb_data <= csr_old;
                  if (alu_wr) begin
                    case (csr_addr)
                      CSR_MSTATUS:  mstatus_reg  <= alu_new;
                      CSR_MTVEC:    mtvec_reg    <= alu_new;
                      CSR_MSCRATCH: mscratch_reg <= alu_new;
                      CSR_MEPC:     mepc_reg     <= alu_new & LOW2_MASK;
                      CSR_MCAUSE:   mcause_reg   <= alu_new;
                      default: ;
                    endcase
                  end
                end
              end
              OP_ECALL, OP_EBREAK: begin
                mepc_reg        <= pc & LOW2_MASK;
                trap_ebreak_reg <= (op_e'(op) == OP_EBREAK);
              end
              OP_MRET: begin
                mstatus_reg[MSTATUS_MIE]                   <= mstatus_reg[MSTATUS_MPIE];
                mstatus_reg[MSTATUS_MPIE]                  <= 1'b1;
                mstatus_reg[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
                resp_valid   <= 1'b1;
                redirect_vld <= 1'b1;
                redirect_pc  <= mepc_reg;
              end
              default: ;
            endcase
          end
        end
        ST_TRAP: begin
          mcause_reg <= trap_ebreak_reg ? XLEN'(MCAUSE_EBREAK) : XLEN'(MCAUSE_ECALL);
          mstatus_reg[MSTATUS_MPIE]                  <= mstatus_reg[MSTATUS_MIE];
          mstatus_reg[MSTATUS_MIE]                   <= 1'b0;
          mstatus_reg[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
          resp_valid   <= 1'b1;
          redirect_vld <= 1'b1;
          redirect_pc  <= mtvec_reg & LOW2_MASK;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_csr_trap_unit.sv
// Self-checking bench: ordered vector table with a response scoreboard,
// plus hand-written reset and reset-during-trap sequences.
module tb_sys_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [2:0]  func3;
  logic [11:0] csr_addr;
  logic [63:0] src1;
  logic [4:0]  src1_id;
  logic [63:0] pc;
  logic [4:0]  dst_id;
  logic        resp_valid;
  logic        wb_vld;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        redirect_vld;
  logic [63:0] redirect_pc;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sys_csr_trap_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .op           (op),
    .func3        (func3),
    .csr_addr     (csr_addr),
    .src1         (src1),
    .src1_id      (src1_id),
    .pc           (pc),
    .dst_id       (dst_id),
    .resp_valid   (resp_valid),
    .wb_vld       (wb_vld),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .illegal      (illegal)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [63:0] src1;
    logic [4:0]  rs1;
    logic [63:0] pc;
    logic [4:0]  rd;
    int          lat;
    logic        wbv;
    logic [63:0] wbd;
    logic        redir;
    logic [63:0] rpc;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [1:0] o, input logic [2:0] f, input logic [11:0] a,
                              input logic [63:0] s, input logic [4:0] r1, input logic [63:0] p,
                              input logic [4:0] rd, input int lat, input logic wbv,
                              input logic [63:0] wbd, input logic redir, input logic [63:0] rpc,
                              input logic ill);
    vec_t v;
    v.op = o; v.f3 = f; v.addr = a; v.src1 = s; v.rs1 = r1; v.pc = p; v.rd = rd;
    v.lat = lat; v.wbv = wbv; v.wbd = wbd; v.redir = redir; v.rpc = rpc; v.ill = ill;
    return v;
  endfunction

  // CSR read (csrrs rd, csr, x0) expecting a given value
  function automatic vec_t rd_csr(input logic [11:0] a, input logic [4:0] rd, input logic [63:0] v);
    return mk(2'd0, 3'b010, a, 64'hdead_beef, 5'd0, 64'd0, rd, 1, 1'b1, v, 1'b0, 64'd0, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    vec_t e;
    int   cyc;
    bit   got;
    exp_q.push_back(v);
    @(negedge clk);
    chk($sformatf("v%0d ready_before", idx), {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; op = v.op; func3 = v.f3; csr_addr = v.addr;
    src1 = v.src1; src1_id = v.rs1; pc = v.pc; dst_id = v.rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = 2'($urandom); func3 = 3'($urandom); csr_addr = 12'($urandom);
    src1 = {$urandom, $urandom}; src1_id = 5'($urandom); pc = {$urandom, $urandom};
    dst_id = 5'($urandom);
    cyc = 0; got = 0;
    while (cyc < 8 && !got) begin
      @(negedge clk);
      cyc++;
      chk($sformatf("v%0d busy_ready", idx), {63'd0, req_ready}, 64'd0);
      if (resp_valid) got = 1;
    end
    e = exp_q.pop_front();
    if (!got) begin
      checks++; errors++;
      $display("FAIL v%0d timeout: no resp_valid within %0d cycles", idx, cyc);
    end else begin
      chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(e.lat));
      chk($sformatf("v%0d wb_vld", idx), {63'd0, wb_vld}, {63'd0, e.wbv});
      chk($sformatf("v%0d illegal", idx), {63'd0, illegal}, {63'd0, e.ill});
      chk($sformatf("v%0d redirect_vld", idx), {63'd0, redirect_vld}, {63'd0, e.redir});
      if (e.wbv) begin
        chk($sformatf("v%0d wb_addr", idx), {59'd0, wb_addr}, {59'd0, e.rd});
        chk($sformatf("v%0d wb_data", idx), wb_data, e.wbd);
      end
      if (e.redir) chk($sformatf("v%0d redirect_pc", idx), redirect_pc, e.rpc);
      @(negedge clk);
      chk($sformatf("v%0d resp_pulse", idx), {63'd0, resp_valid}, 64'd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, " resp_valid"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, " wb_vld"}, {63'd0, wb_vld}, 64'd0);
    chk({tag, " redirect_vld"}, {63'd0, redirect_vld}, 64'd0);
    chk({tag, " illegal"}, {63'd0, illegal}, 64'd0);
    chk({tag, " wb_data"}, wb_data, 64'd0);
    chk({tag, " redirect_pc"}, redirect_pc, 64'd0);
  endtask

  localparam logic [63:0] MS_RST = 64'h0000_000a_0000_1800;

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; op = '0; func3 = '0; csr_addr = '0;
    src1 = '0; src1_id = '0; pc = '0; dst_id = '0;

    // op, f3, addr, src1, rs1, pc, rd, lat, wbv, wbd, redir, rpc, ill
    vecs.push_back(mk(0, 3'b010, 12'h300, 64'h0, 0, 0, 5, 1, 1, MS_RST, 0, 0, 0));
    vecs.push_back(rd_csr(12'h300, 6, MS_RST));
    vecs.push_back(mk(0, 3'b001, 12'h305, 64'h8000_0103, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(rd_csr(12'h305, 7, 64'h8000_0103));
    vecs.push_back(mk(0, 3'b110, 12'h300, 64'h0, 8, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 12'h000, 64'h0, 0, 64'h8000_0040, 0, 2, 0, 0, 1, 64'h8000_0100, 0));
    vecs.push_back(rd_csr(12'h341, 8, 64'h8000_0040));
    vecs.push_back(rd_csr(12'h342, 9, 64'd11));
    vecs.push_back(rd_csr(12'h300, 10, 64'h0000_000a_0000_1880));
    vecs.push_back(mk(3, 3'b000, 12'h000, 64'h0, 0, 64'h10, 0, 1, 0, 0, 1, 64'h8000_0040, 0));
    vecs.push_back(rd_csr(12'h300, 11, 64'h0000_000a_0000_1888));
    vecs.push_back(mk(0, 3'b111, 12'h300, 64'h0, 8, 0, 12, 1, 1, 64'h0000_000a_0000_1888, 0, 0, 0));
    vecs.push_back(mk(0, 3'b110, 12'h340, 64'h0, 5'h1f, 0, 13, 1, 1, 64'h0, 0, 0, 0));
    vecs.push_back(rd_csr(12'h340, 14, 64'h1f));
    vecs.push_back(rd_csr(12'h300, 15, 64'h0000_000a_0000_1880));
    vecs.push_back(mk(0, 3'b001, 12'h7c0, 64'hffff, 1, 0, 3, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b100, 12'h340, 64'h55, 2, 0, 4, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 12'h340, 64'h55, 2, 0, 4, 1, 0, 0, 0, 0, 1));
    vecs.push_back(rd_csr(12'h340, 1, 64'h1f));
    vecs.push_back(mk(2, 3'b000, 12'h000, 64'h0, 0, 64'h8000_0203, 0, 2, 0, 0, 1, 64'h8000_0100, 0));
    vecs.push_back(rd_csr(12'h341, 16, 64'h8000_0200));
    vecs.push_back(rd_csr(12'h342, 17, 64'd3));
    vecs.push_back(mk(0, 3'b011, 12'h305, 64'h100, 3, 0, 2, 1, 1, 64'h8000_0103, 0, 0, 0));
    vecs.push_back(rd_csr(12'h305, 18, 64'h8000_0003));
    vecs.push_back(mk(0, 3'b001, 12'h341, 64'h1_2347, 4, 0, 5, 1, 1, 64'h8000_0200, 0, 0, 0));
    vecs.push_back(rd_csr(12'h341, 19, 64'h1_2344));
    vecs.push_back(mk(0, 3'b011, 12'h340, 64'hffff, 0, 0, 20, 1, 1, 64'h1f, 0, 0, 0));
    vecs.push_back(rd_csr(12'h340, 21, 64'h1f));
    vecs.push_back(mk(0, 3'b001, 12'h342, 64'hdead_beef_0000_0007, 6, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(rd_csr(12'h342, 22, 64'hdead_beef_0000_0007));
    vecs.push_back(mk(3, 3'b000, 12'h000, 64'h0, 0, 64'h0, 0, 1, 0, 0, 1, 64'h1_2344, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    n = 0;
    foreach (vecs[i]) begin
      run(vecs[i], n);
      n++;
    end

    // Reset arriving while an ecall sits in TRAP must discard it entirely
    @(negedge clk);
    req_valid = 1'b1; op = 2'd1; pc = 64'h8000_0444; func3 = '0; csr_addr = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("trap_rst in_trap_ready", {63'd0, req_ready}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("trap_rst");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("trap_rst no_resp", {63'd0, resp_valid}, 64'd0);
    end
    run(rd_csr(12'h342, 23, 64'd0), 100);
    run(rd_csr(12'h300, 24, MS_RST), 101);
    run(rd_csr(12'h341, 25, 64'd0), 102);
    run(rd_csr(12'h305, 26, 64'd0), 103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_csr_trap_unit.md
Name: sys_csr_trap_unit

Overview:
- Parametrised machine-mode system unit in the EXU, replacing the fixed four-entry CSR/ecall controller.
- Owns the CSR storage internally: mstatus, mtvec, mscratch, mepc, mcause.
- Executes csrrw/s/c and the immediate variants, plus ecall, ebreak and mret, through a valid/ready request, a multi-cycle trap sequencer and a registered writeback/redirect response.

Parameters:
- XLEN, 64, datapath and CSR width.
- MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value.
- MCAUSE_ECALL, 11, cause code written on ecall.
- MCAUSE_EBREAK, 3, cause code written on ebreak.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept
- op  in  2  0=CSR, 1=ECALL, 2=EBREAK, 3=MRET
- func3  in  3  CSR subop: 001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci
- csr_addr  in  12  CSR address
- src1  in  XLEN  rs1 value
- src1_id  in  5  rs1 index, doubles as zimm
- pc  in  XLEN  pc of the instruction
- dst_id  in  5  rd index
- resp_valid  out  1  one-cycle completion pulse
- wb_vld  out  1  writeback valid
- wb_addr  out  5  rd
- wb_data  out  XLEN  old CSR value
- redirect_vld  out  1  pc redirect
- redirect_pc  out  XLEN  redirect target
- illegal  out  1  unknown CSR or func3

Behaviour:
- Reset:
  - state IDLE; mstatus=MSTATUS_RST; all other CSRs 0.
  - All outputs 0 except req_ready=1.
  - Reset mid-sequence discards the pending trap, with no partial retirement.
- Address map: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
- Handshake: accept = req_valid & req_ready; req_ready = (state==IDLE).
- FSM states: IDLE, TRAP, RESP.
- CSR op accepted in cycle T:
  - Old value is latched into wb_data.
  - New value is computed and written at the T edge:
    - rw: new = operand.
    - rs: new = old | operand.
    - rc: new = old & ~operand.
    - operand = src1 for the register forms; zero-extended src1_id for the i-forms.
  - Write suppressed for rs/rc/rsi/rci when src1_id==0.
  - mepc writes force bits[1:0]=0; mcause writes are full width.
  - Response: state→RESP, resp_valid at T+1.
    - wb_vld = (dst_id!=0); wb_addr = dst_id.
- Illegal (unmapped csr_addr, or func3 in {000,100}):
  - No CSR write.
  - T+1: resp_valid=1, illegal=1, wb_vld=0.
- ECALL/EBREAK accepted at T:
  - T edge: mepc<=pc with bits[1:0]=0; state→TRAP.
  - T+1 edge:
    - mcause<=MCAUSE_ECALL or MCAUSE_EBREAK.
    - mstatus.MPIE(bit7)<=MIE(bit3); MIE<=0; MPP(bits12:11)<=2'b11.
    - state→RESP.
  - T+2: resp_valid=1, redirect_vld=1, redirect_pc={mtvec[XLEN-1:2],2'b00}; wb_vld=0.
- MRET accepted at T:
  - T edge: MIE<=MPIE; MPIE<=1; MPP<=2'b11; state→RESP.
  - T+1: resp_valid=1, redirect_vld=1, redirect_pc=mepc.
- RESP always returns to IDLE next cycle. resp_valid, wb_vld, redirect_vld and illegal are single-cycle pulses.
- Back-to-back ordering: a write completed by an earlier op is visible to the next accepted op. Example: csrrw mtvec followed by ecall redirects to the new mtvec.
- Request fields are sampled only at accept; they are don't-care while busy.

Decomposition:
- Package sys_pkg holds:
  - op enum.
  - func3 constants.
  - CSR address localparams.
  - mstatus bit-position constants (MIE=3, MPIE=7, MPP=12:11).
- One natural sub-module, csr_alu: purely combinational rw/rs/rc/operand-select and write-suppress logic, instantiated once. FSM and CSR storage stay in the top.

Test Plan:
- Reset release: csrrs x5,mstatus,x0 (src1_id=0) → resp at T+1, wb_data=64'ha00001800, wb_addr=5; mstatus unchanged.
- csrrw mtvec with src1=0x8000_0103, dst_id=0, then csrrs mtvec, x0 → first wb_vld=0; second wb_data=0x8000_0103.
- ecall with pc=0x8000_0040, mstatus.MIE=1:
  - resp at T+2; redirect_pc=0x8000_0100 (mtvec low bits masked).
  - mepc=0x8000_0040, mcause=11.
  - MIE=0, MPIE=1; req_ready=0 during T+1..T+2.
- mret after the ecall → redirect_pc=0x8000_0040 at T+1; MIE=1, MPIE=1.
- csrrci mstatus with zimm=8, then csrrsi mscratch with zimm=0x1f → MIE cleared; mscratch=0x1f.
- Illegal cases:
  - csr_addr=0x7c0 → illegal=1, wb_vld=0, no CSR change.
  - rst_n low during ecall TRAP state → mcause stays 0, no resp, mstatus=MSTATUS_RST.
